// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and sizing helpers for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RSP} arb_state_t;
    typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned STARVE_CNT_W     = $clog2(STARVE_LIMIT_DEF + 1);

    // Counter must hold the value STARVE_LIMIT itself, hence +1.
    function automatic int unsigned starve_cnt_w(input int unsigned lim);
        return $clog2(lim + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_prio_pick.sv
// Combinational winner selection: data has priority unless fetch is starving.
module arb_prio_pick (
    input  logic if_valid_i,
    input  logic d_valid_i,
    input  logic starve_hit_i,
    output logic any_valid_o,
    output logic pick_d_o
);
    assign any_valid_o = if_valid_i | d_valid_i;
    assign pick_d_o    = d_valid_i & ~(if_valid_i & starve_hit_i);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction in flight.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_rsp_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_valid_i,
    output logic              d_req_ready_o,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic              d_we_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_rsp_valid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    localparam int unsigned CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              if_rsp_q, d_rsp_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    logic any_valid, pick_d, starve_hit, grant;

    assign starve_hit = (cnt_q == CNT_MAX);

    arb_prio_pick u_pick (
        .if_valid_i   (if_req_valid_i),
        .d_valid_i    (d_req_valid_i),
        .starve_hit_i (starve_hit),
        .any_valid_o  (any_valid),
        .pick_d_o     (pick_d)
    );

    assign grant = (state_q == ARB_IDLE) && any_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= ARB_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (any_valid)       state_d = ARB_REQ;
            ARB_REQ:  if (mem_req_ready_i) state_d = ARB_RSP;
            ARB_RSP:  if (mem_rsp_valid_i) state_d = ARB_IDLE;
            default:                       state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        if_req_ready_o  = grant & ~pick_d;
        d_req_ready_o   = grant & pick_d;
        mem_req_valid_o = (state_q == ARB_REQ);
    end

    // Request latch and starvation bookkeeping happen only on an IDLE grant.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else if (grant) begin
            if (pick_d) begin
                owner_q <= OWN_D;
                addr_q  <= d_addr_i;
                we_q    <= d_we_i;
                wdata_q <= d_wdata_i;
                if (!if_req_valid_i)   cnt_q <= '0;
                else if (!starve_hit)  cnt_q <= cnt_q + 1'b1;
            end else begin
                owner_q <= OWN_IF;
                addr_q  <= if_addr_i;
                we_q    <= 1'b0;
                wdata_q <= '0;
                cnt_q   <= '0;
            end
        end
    end

    // Responses are only honoured in RSP, so stale ones after reset are dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            if_rsp_q   <= 1'b0;
            d_rsp_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if_rsp_q <= 1'b0;
            d_rsp_q  <= 1'b0;
            if (state_q == ARB_RSP && mem_rsp_valid_i) begin
                if (owner_q == OWN_D) begin
                    d_rsp_q   <= 1'b1;
                    d_rdata_q <= mem_rdata_i;
                end else begin
                    if_rsp_q   <= 1'b1;
                    if_rdata_q <= mem_rdata_i;
                end
            end
        end
    end

    assign mem_addr_o     = addr_q;
    assign mem_we_o       = we_q;
    assign mem_wdata_o    = wdata_q;
    assign if_rsp_valid_o = if_rsp_q;
    assign if_rdata_o     = if_rdata_q;
    assign d_rsp_valid_o  = d_rsp_q;
    assign d_rdata_o      = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, contention, starvation, stall, reset mid-flight.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req_valid, if_req_ready, if_rsp_valid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req_valid, d_req_ready, d_we, d_rsp_valid;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_valid_i(if_req_valid), .if_req_ready_o(if_req_ready), .if_addr_i(if_addr),
        .if_rsp_valid_o(if_rsp_valid), .if_rdata_o(if_rdata),
        .d_req_valid_i(d_req_valid), .d_req_ready_o(d_req_ready), .d_addr_i(d_addr),
        .d_we_i(d_we), .d_wdata_i(d_wdata), .d_rsp_valid_o(d_rsp_valid), .d_rdata_o(d_rdata),
        .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rdata_i(mem_rdata)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From a REQ cycle: accept immediately, respond one cycle later; ends in the pulse cycle.
    task automatic serve(input logic [DATA_W-1:0] rd);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd;
        step();
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req_valid = 0; if_addr = '0; d_req_valid = 0; d_addr = '0; d_we = 0; d_wdata = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
        step(); step();
        n_chk++;
        if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_req_valid, mem_we} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000",
                {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid, mem_req_valid, mem_we});
        end
        n_chk++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h ird %h drd %h want 0",
                mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        if_req_valid = 1; if_addr = 64'h10;
        #1;
        n_chk++;
        if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL sf_ready: if %b d %b want 1 0", if_req_ready, d_req_ready);
        end
        step();
        if_req_valid = 0; if_addr = '0;
        n_chk++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 64'h10 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL sf_memreq: v %b addr %h we %b want 1 10 0", mem_req_valid, mem_addr, mem_we);
        end
        serve(64'h13);
        n_chk++;
        if (if_rsp_valid !== 1'b1 || if_rdata !== 64'h13 || d_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL sf_rsp: ifv %b ird %h dv %b want 1 13 0", if_rsp_valid, if_rdata, d_rsp_valid);
        end
        step();
        n_chk++;
        if (if_rsp_valid !== 1'b0 || if_rdata !== 64'h13 || mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL sf_pulse_end: ifv %b ird %h memv %b want 0 13 0", if_rsp_valid, if_rdata, mem_req_valid);
        end
    endtask

    task automatic test_contention();
        if_req_valid = 1; if_addr = 64'h20;
        d_req_valid = 1; d_addr = 64'h40; d_we = 1; d_wdata = 64'hDEAD;
        #1;
        n_chk++;
        if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL ct_grant_d: d %b if %b want 1 0", d_req_ready, if_req_ready);
        end
        step();
        d_req_valid = 0; d_we = 0; d_wdata = '0;
        #1;
        n_chk++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 64'h40 || mem_we !== 1'b1 || mem_wdata !== 64'hDEAD
            || if_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL ct_memreq: v %b addr %h we %b wd %h ifr %b want 1 40 1 dead 0",
                mem_req_valid, mem_addr, mem_we, mem_wdata, if_req_ready);
        end
        serve(64'h0);
        n_chk++;
        if (d_rsp_valid !== 1'b1 || if_rsp_valid !== 1'b0 || if_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL ct_d_rsp: dv %b ifv %b ifr %b want 1 0 1", d_rsp_valid, if_rsp_valid, if_req_ready);
        end
        step();
        if_req_valid = 0;
        n_chk++;
        if (mem_addr !== 64'h20 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL ct_if_req: addr %h we %b want 20 0", mem_addr, mem_we);
        end
        serve(64'hABCD);
        n_chk++;
        if (if_rsp_valid !== 1'b1 || if_rdata !== 64'hABCD || d_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL ct_if_rsp: ifv %b ird %h dv %b want 1 abcd 0", if_rsp_valid, if_rdata, d_rsp_valid);
        end
        step();
    endtask

    task automatic test_starvation();
        logic exp_if;
        if_req_valid = 1; if_addr = 64'h100;
        d_req_valid = 1; d_addr = 64'h200; d_we = 0;
        for (int g = 0; g < 10; g++) begin
            exp_if = (g == 4 || g == 9);
            #1;
            n_chk++;
            if (if_req_ready !== exp_if || d_req_ready !== ~exp_if) begin
                n_fail++; $display("FAIL starve_grant%0d: if %b d %b want %b %b",
                    g, if_req_ready, d_req_ready, exp_if, ~exp_if);
            end
            step();
            serve(64'(g));
        end
        if_req_valid = 0; d_req_valid = 0;
        step();
    endtask

    task automatic test_stall();
        if_req_valid = 1; if_addr = 64'h80;
        step();
        if_req_valid = 0; if_addr = '0;
        d_req_valid = 1; d_addr = 64'h300;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_chk++;
            if (mem_req_valid !== 1'b1 || mem_addr !== 64'h80 || if_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_c%0d: v %b addr %h ifr %b dr %b want 1 80 0 0",
                    c, mem_req_valid, mem_addr, if_req_ready, d_req_ready);
            end
            step();
        end
        d_req_valid = 0;
        serve(64'h77);
        n_chk++;
        if (if_rsp_valid !== 1'b1 || if_rdata !== 64'h77 || mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_rsp: ifv %b ird %h memv %b want 1 77 0", if_rsp_valid, if_rdata, mem_req_valid);
        end
        step();
        n_chk++;
        if (mem_req_valid !== 1'b0 || if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_one_txn: memv %b ifv %b dv %b want 0 0 0", mem_req_valid, if_rsp_valid, d_rsp_valid);
        end
    endtask

    task automatic test_reset_in_rsp();
        if_req_valid = 1; if_addr = 64'hA0;
        step();
        if_req_valid = 0;
        mem_req_ready = 1;
        step();
        mem_req_ready = 0;
        rst_n = 0;
        step();
        rst_n = 1;
        mem_rsp_valid = 1; mem_rdata = 64'hBAD;
        step();
        mem_rsp_valid = 0; mem_rdata = '0;
        n_chk++;
        if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0 || if_rdata !== '0) begin
            n_fail++; $display("FAIL rst_rsp_drop: ifv %b dv %b memv %b ird %h want 0 0 0 0",
                if_rsp_valid, d_rsp_valid, mem_req_valid, if_rdata);
        end
        if_req_valid = 1; if_addr = 64'hB0;
        #1;
        n_chk++;
        if (if_req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_idle_grant: ifr %b want 1", if_req_ready);
        end
        step();
        if_req_valid = 0;
        n_chk++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 64'hB0) begin
            n_fail++; $display("FAIL rst_next_req: v %b addr %h want 1 b0", mem_req_valid, mem_addr);
        end
        serve(64'h55);
        n_chk++;
        if (if_rsp_valid !== 1'b1 || if_rdata !== 64'h55) begin
            n_fail++; $display("FAIL rst_next_rsp: ifv %b ird %h want 1 55", if_rsp_valid, if_rdata);
        end
        step();
    endtask

    task automatic test_spurious_rsp();
        mem_rsp_valid = 1; mem_rdata = 64'hFFFF;
        step(); step();
        n_chk++;
        if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || mem_req_valid !== 1'b0
            || if_rdata !== 64'h55 || d_rdata !== 64'h0) begin
            n_fail++; $display("FAIL spur_rsp: ifv %b dv %b memv %b ird %h drd %h want 0 0 0 55 0",
                if_rsp_valid, d_rsp_valid, mem_req_valid, if_rdata, d_rdata);
        end
        mem_rsp_valid = 0; mem_rdata = '0;
        // Counter was cleared by the last fetch, so data must still win a tie.
        if_req_valid = 1; d_req_valid = 1; d_addr = 64'h400;
        #1;
        n_chk++;
        if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            n_fail++; $display("FAIL spur_cnt: dr %b ifr %b want 1 0", d_req_ready, if_req_ready);
        end
        step();
        if_req_valid = 0; d_req_valid = 0;
        serve(64'h99);
        n_chk++;
        if (d_rsp_valid !== 1'b1 || d_rdata !== 64'h99) begin
            n_fail++; $display("FAIL spur_d_rsp: dv %b drd %h want 1 99", d_rsp_valid, d_rdata);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_stall();
        test_reset_in_rsp();
        test_spurious_rsp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one backing memory port between the CPU's instruction-fetch requester (port 0) and data load/store requester (port 1).
- Keeps one transaction outstanding at a time and uses a three-state FSM to issue it and await its response.
- Data port has fixed priority; a starvation counter forces a fetch grant after a bounded run of data wins.
- Sits between the pipeline's IF/MEM stages and a unified memory, replacing the separate combinational icache/dcache arrays.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- STARVE_LIMIT, 4, consecutive data grants that are allowed while fetch waits before fetch is forced (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- if_req_valid_i  in  1  fetch request valid
- if_req_ready_o  out  1  fetch request accepted this cycle
- if_addr_i  in  ADDR_W  fetch address
- if_rsp_valid_o  out  1  fetch response valid (1-cycle pulse)
- if_rdata_o  out  DATA_W  fetch read data
- d_req_valid_i  in  1  data request valid
- d_req_ready_o  out  1  data request accepted this cycle
- d_addr_i  in  ADDR_W  data address
- d_we_i  in  1  data write enable
- d_wdata_i  in  DATA_W  data write value
- d_rsp_valid_o  out  1  data response or write ack (1-cycle pulse)
- d_rdata_o  out  DATA_W  data read data
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  ADDR_W  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  DATA_W  memory write data
- mem_rsp_valid_i  in  1  memory response valid (reads and writes)
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset (rst_ni=0 at posedge):
  - state=IDLE, starve counter=0.
  - All *_valid_o and *_ready_o are 0; addr/wdata/rdata outputs are 0.
  - Any in-flight memory transaction is abandoned. A later mem_rsp_valid_i is ignored because the FSM is not in RSP.
- IDLE:
  - If no request is valid, stay in IDLE.
  - Otherwise choose the owner:
    - fetch, if d_req_valid_i=0;
    - fetch, if both are valid and starve counter == STARVE_LIMIT;
    - data, otherwise.
  - The winner's req_ready_o=1 combinationally in this cycle. Loser's ready=0.
  - Latch the winner's addr/we/wdata and the owner into registers (fetch has we=0). Next state is REQ.
- REQ:
  - mem_req_valid_o=1 and mem_* outputs are driven from the registers.
  - Stay in REQ until mem_req_ready_i=1; then go to RSP.
  - The request is held stable while waiting.
- RSP:
  - mem_req_valid_o=0. Wait for mem_rsp_valid_i.
  - On mem_rsp_valid_i=1, register mem_rdata_i into the owner's rdata_o and set the owner's rsp_valid_o=1 in the next cycle only. Go to IDLE.
  - rdata_o holds its value until the next response to that port.
- Latency:
  - Request accepted in cycle N (IDLE).
  - mem_req_valid_o is 1 in N+1.
  - With mem ready immediately and response one cycle later, rsp_valid_o is 1 in N+3.
  - Minimum spacing between accepts is 3 cycles. A new accept may coincide with the previous rsp_valid_o pulse.
- Starve counter:
  - Updated only on IDLE grants.
  - Data grant with if_req_valid_i=1: counter increments, saturating at STARVE_LIMIT.
  - Data grant with if_req_valid_i=0: counter clears to 0.
  - Fetch grant: counter clears to 0.
- Simultaneous events:
  - mem_rsp_valid_i in IDLE or REQ is ignored.
  - Requests that arrive while the FSM is in REQ or RSP wait; ready stays 0.
  - Requesters must hold valid/addr until ready. The arbiter does not check this.
- Widths:
  - Addresses and data pass through unmodified. No alignment checks.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RSP} arb_state_t;
  - typedef enum logic {OWN_IF, OWN_D} arb_owner_t;
  - localparam for the starve counter width, $clog2(STARVE_LIMIT+1).
- One sub-module, arb_prio_pick: combinational winner selection from (if_valid, d_valid, starve_hit). It is kept separate so it can be unit-tested.

Test Plan:
- Single fetch to addr 0x10; mem ready immediately; rsp 1 cycle later with rdata 0x00000013 -> if_req_ready_o in cycle 1, mem_req_valid_o with mem_addr_o=0x10 in cycle 2, if_rsp_valid_o pulse with if_rdata_o=0x13 in cycle 4, d_rsp_valid_o stays 0.
- Both requesters valid in the same cycle (fetch addr 0x20, data write addr 0x40 data 0xDEAD) -> data granted first (mem_we_o=1, mem_wdata_o=0xDEAD); fetch granted on the next IDLE visit; each rsp_valid routed to the correct port.
- Data and fetch continuously valid, STARVE_LIMIT=4 -> grant order D,D,D,D,F,D,D,D,D,F; counter returns to 0 after each F.
- mem_req_ready_i held 0 for 5 cycles -> mem_req_valid_o and mem_addr_o stay stable for all 5 cycles, both req_ready_o stay 0, one transaction total.
- rst_ni driven 0 for one cycle while in RSP, then mem_rsp_valid_i=1 -> no rsp_valid_o pulse on either port; FSM in IDLE; the next fetch completes normally.
- Spurious mem_rsp_valid_i=1 in IDLE with no requests -> no output change; counter unchanged.
